// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-back path.
package rf_pkg;

  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int REG_ZERO = 0;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping modulo N, and moves the pointer past the winner when advance is set.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    gnt      = '0;
    ptr_next = ptr;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        gnt[(int'(ptr) + k) % N] = 1'b1;
        ptr_next                 = PW'((int'(ptr) + k + 1) % N);
        found                    = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler: arbitrates requesters onto the single register-file
// write port and keeps a busy scoreboard for RAW/WAW stall detection.
module rf_wb_scheduler
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = REG_AW,
  parameter int DW      = REG_DW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  input  logic                  rsv_valid,
  input  logic [AW-1:0]         rsv_addr,
  output logic                  rsv_ready,
  input  logic [AW-1:0]         chk_addr_a,
  input  logic [AW-1:0]         chk_addr_b,
  output logic                  chk_stall,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata,
  output logic [NUM_REGS-1:0]   busy_vec
);

  logic [NUM_REQ-1:0] gnt;
  logic               accept;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  logic               sel_nonzero;
  logic [NUM_REGS-1:0] busy_next;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (1'b1),
    .gnt     (gnt)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  assign sel_nonzero = (sel_addr != AW'(REG_ZERO));

  // x0 writes are accepted but swallowed; address/data hold so the port only
  // changes when a real write is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= accept && sel_nonzero;
      if (accept && sel_nonzero) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

  assign rsv_ready = rsv_valid && !busy_vec[rsv_addr];

  // Clear on the draining write and set on a reservation can hit different
  // registers in one cycle; a busy bit blocks a same-register reserve.
  always_comb begin
    busy_next = busy_vec;
    if (rf_we) begin
      busy_next[rf_waddr] = 1'b0;
    end
    if (rsv_ready) begin
      busy_next[rsv_addr] = 1'b1;
    end
    busy_next[REG_ZERO] = 1'b0;
  end

  // NOTE: the scoreboard is control state, not a data array, so every bit is
  // reset; stale busy bits would stall issue forever.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

  assign chk_stall = busy_vec[chk_addr_a] | busy_vec[chk_addr_b];

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler with hand-computed expectations.
module tb_rf_wb_scheduler;
  import rf_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int AW      = REG_AW;
  localparam int DW      = REG_DW;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic                  rsv_valid;
  reg_addr_t             rsv_addr;
  logic                  rsv_ready;
  reg_addr_t             chk_addr_a;
  reg_addr_t             chk_addr_b;
  logic                  chk_stall;
  logic                  rf_we;
  reg_addr_t             rf_waddr;
  reg_data_t             rf_wdata;
  logic [NUM_REGS-1:0]   busy_vec;

  int checks = 0;
  int errors = 0;

  rf_wb_scheduler #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .rsv_ready  (rsv_ready),
    .chk_addr_a (chk_addr_a),
    .chk_addr_b (chk_addr_b),
    .chk_stall  (chk_stall),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy_vec   (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_addr   = '0;
    req_data   = '0;
    rsv_valid  = 1'b0;
    rsv_addr   = '0;
    chk_addr_a = '0;
    chk_addr_b = '0;
    step();
    step();
    check("reset_we",    32'(rf_we),    32'h0);
    check("reset_waddr", 32'(rf_waddr), 32'h0);
    check("reset_wdata", rf_wdata,      32'h0);
    check("reset_busy",  busy_vec,      32'h0);
    reset = 1'b0;

    // Single write: reserve x5, then req0 writes x5.
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    #1 check("t1_rsv_ready", 32'(rsv_ready), 32'h1);
    step();
    rsv_valid = 1'b0;
    check("t1_busy_set", busy_vec, 32'h0000_0020);
    req_valid = 2'b01; req_addr[0 +: AW] = 5'd5; req_data[0 +: DW] = 32'hDEAD_BEEF;
    #1 check("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("t1_we",        32'(rf_we),    32'h1);
    check("t1_waddr",     32'(rf_waddr), 32'h5);
    check("t1_wdata",     rf_wdata,      32'hDEAD_BEEF);
    check("t1_busy_n1",   busy_vec,      32'h0000_0020);
    step();
    check("t1_we_off",    32'(rf_we),    32'h0);
    check("t1_busy_n2",   busy_vec,      32'h0);
    check("t1_waddr_hold", 32'(rf_waddr), 32'h5);
    check("t1_wdata_hold", rf_wdata,      32'hDEAD_BEEF);

    // Unreserved write from req1 (pointer is 1) passes through, pointer -> 0.
    req_valid = 2'b10; req_addr[AW +: AW] = 5'd12; req_data[DW +: DW] = 32'h0000_0012;
    #1 check("pt_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    check("pt_we",    32'(rf_we),    32'h1);
    check("pt_waddr", 32'(rf_waddr), 32'hC);
    check("pt_busy",  busy_vec,      32'h0);

    // Contention: both valid for 4 cycles, grants alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b11;
      req_addr[0 +: AW] = 5'd10; req_data[0 +: DW]  = 32'h1000 + 32'(i);
      req_addr[AW +: AW] = 5'd11; req_data[DW +: DW] = 32'h2000 + 32'(i);
      #1 check("ct_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      step();
      check("ct_we",    32'(rf_we),    32'h1);
      check("ct_waddr", 32'(rf_waddr), (i % 2 == 0) ? 32'hA : 32'hB);
      check("ct_wdata", rf_wdata,      (i % 2 == 0) ? 32'h1000 + 32'(i) : 32'h2000 + 32'(i));
    end
    req_valid = '0;
    step();
    check("ct_we_off", 32'(rf_we), 32'h0);

    // Hazard on x7.
    rsv_valid = 1'b1; rsv_addr = 5'd7; chk_addr_a = 5'd7; chk_addr_b = 5'd0;
    #1 check("hz_rsv_ready", 32'(rsv_ready), 32'h1);
    check("hz_stall_pre", 32'(chk_stall), 32'h0);
    step();
    #1 check("hz_stall", 32'(chk_stall), 32'h1);
    check("hz_rsv_busy", 32'(rsv_ready), 32'h0);
    rsv_valid = 1'b0;
    req_valid = 2'b01; req_addr[0 +: AW] = 5'd7; req_data[0 +: DW] = 32'h0000_0077;
    #1 check("hz_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("hz_we",       32'(rf_we),     32'h1);
    check("hz_stall_n1", 32'(chk_stall), 32'h1);
    step();
    check("hz_stall_n2", 32'(chk_stall), 32'h0);
    check("hz_busy_n2",  busy_vec,       32'h0);

    // x0: reservation and write are accepted but have no effect.
    rsv_valid = 1'b1; rsv_addr = 5'd0; chk_addr_a = 5'd0; chk_addr_b = 5'd0;
    req_valid = 2'b10; req_addr[AW +: AW] = 5'd0; req_data[DW +: DW] = 32'h0000_1234;
    #1 check("x0_rsv_ready", 32'(rsv_ready), 32'h1);
    check("x0_req_ready", 32'(req_ready), 32'h2);
    check("x0_stall",     32'(chk_stall), 32'h0);
    step();
    rsv_valid = 1'b0; req_valid = '0;
    check("x0_we",         32'(rf_we),    32'h0);
    check("x0_busy",       busy_vec,      32'h0);
    check("x0_waddr_hold", 32'(rf_waddr), 32'h7);
    check("x0_wdata_hold", rf_wdata,      32'h0000_0077);

    // Simultaneous: reserve x3 while the write to x9 drains.
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    step();
    rsv_valid = 1'b0;
    req_valid = 2'b01; req_addr[0 +: AW] = 5'd9; req_data[0 +: DW] = 32'h0000_0099;
    #1 check("sm_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    #1 check("sm_rsv_ready", 32'(rsv_ready), 32'h1);
    check("sm_we", 32'(rf_we), 32'h1);
    step();
    rsv_valid = 1'b0;
    check("sm_busy", busy_vec, 32'h0000_0008);

    // Reset mid-operation: pointer is 1, busy has x3 set.
    req_valid = 2'b01; req_addr[0 +: AW] = 5'd4; req_data[0 +: DW] = 32'h0000_0044;
    #1 check("rs_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rs_we",    32'(rf_we),    32'h0);
    check("rs_busy",  busy_vec,      32'h0);
    check("rs_waddr", 32'(rf_waddr), 32'h0);
    req_valid = 2'b11;
    req_addr[0 +: AW] = 5'd20; req_data[0 +: DW]  = 32'hAAAA_0000;
    req_addr[AW +: AW] = 5'd21; req_data[DW +: DW] = 32'hBBBB_0000;
    #1 check("rs_tie_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("rs_tie_waddr", 32'(rf_waddr), 32'h14);
    check("rs_tie_wdata", rf_wdata,      32'hAAAA_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Schedules write-back into the single register-file write port: rf_we, rf_waddr, rf_wdata.
- Requesters are ALU write-back, load unit, and others up to NUM_REQ.
- A fair round-robin arbiter shares the port, with a valid/ready handshake on each requester.
- A 32-entry scoreboard tracks registers with writes outstanding, so issue logic can stall on RAW/WAW hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
- NUM_REQ, 2, number of write-back requesters (2..4)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a write-back pending
- req_ready  out  NUM_REQ  requester i accepted this cycle (one-hot or zero)
- req_addr  in  NUM_REQ*AW  destination register, requester i at bits [i*AW +: AW]
- req_data  in  NUM_REQ*DW  write data, requester i at bits [i*DW +: DW]
- rsv_valid  in  1  issue stage reserves a destination register
- rsv_addr  in  AW  register to reserve
- rsv_ready  out  1  reservation accepted
- chk_addr_a  in  AW  source register A of the instruction being issued
- chk_addr_b  in  AW  source register B of the instruction being issued
- chk_stall  out  1  a source register has a write outstanding
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- busy_vec  out  32  scoreboard state; bit 0 is always 0

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0.
  - Round-robin pointer=0.
  - An in-flight write is dropped: rf_we=0 on the cycle after reset.
- Arbitration (combinational):
  - Among requesters with req_valid=1, grant the first found searching upward from the pointer, modulo NUM_REQ.
  - req_ready is asserted only for the granted requester; all others see 0.
  - If no requester is valid, req_ready=0 and the pointer holds.
  - After granting i, pointer <= (i+1) mod NUM_REQ.
- Write-port latency:
  - A request accepted in cycle N (valid&ready) drives rf_we=1 with its addr/data during cycle N+1.
  - The register file commits it at the end of N+1.
  - One write per cycle maximum.
  - Back-to-back accepts produce back-to-back rf_we pulses.
- x0 handling:
  - A request with addr 0 is accepted but produces rf_we=0 in N+1.
  - A reservation of x0 is accepted (rsv_ready=1) and has no effect.
  - chk on x0 never stalls.
- Scoreboard:
  - Reserve: rsv_ready = rsv_valid && !busy_vec[rsv_addr]. On accept, busy_vec[rsv_addr] <= 1.
  - Clear: busy_vec[rf_waddr] <= 0 at the end of the cycle in which rf_we=1. The cleared bit and the new register value become visible in the same cycle, N+2.
  - Same-cycle reserve and clear of the same register cannot occur, because busy blocks the reserve. Same-cycle reserve of X and clear of Y, with X!=Y, both take effect.
  - A write to an unreserved register passes through unchanged; the scoreboard is unaffected.
- Hazard check (combinational):
  - chk_stall = busy_vec[chk_addr_a] | busy_vec[chk_addr_b].
- Invariants:
  - busy_vec[0] is 0 at all times.
  - rf_waddr and rf_wdata hold their last values while rf_we=0.

Decomposition:
- Package rf_pkg holds:
  - typedef reg_addr_t (logic [AW-1:0]);
  - typedef reg_data_t (logic [DW-1:0]);
  - constant REG_ZERO = 0;
  - constant NUM_REGS = 32.
- Sub-module rr_arbiter (parameter N): inputs req[N], a pointer register, and an advance-on-grant input; output gnt[N] one-hot.
- The scoreboard and write register stay in the top module.

Test Plan:
- Single write: reset, then reserve x5 (rsv_ready=1), then req0 addr=5 data=0xDEADBEEF.
  - Expected: rf_we=1, waddr=5, wdata=0xDEADBEEF one cycle after the accept.
  - Expected: busy_vec[5] is 1 from the reserve until the cycle after rf_we, then 0.
- Contention: req0 and req1 valid in every cycle for 4 cycles.
  - Expected grants: 0,1,0,1.
  - Expected rf_we asserted on 4 consecutive cycles with the matching data.
- Hazard: reserve x7, set chk_addr_a=7.
  - Expected: chk_stall=1 until the write to x7 drains, 0 from N+2.
  - A reserve of x7 while busy gives rsv_ready=0.
- x0: reserve x0 and req1 addr=0 data=0x1234.
  - Expected: rsv_ready=1, req_ready=1, rf_we stays 0, busy_vec=0, chk on x0 gives stall=0.
- Simultaneous: reserve x3 in the same cycle that a write to x9 drains.
  - Expected: busy_vec[3]=1 and busy_vec[9]=0 the next cycle.
- Reset mid-operation: accept req0 to x4, assert reset in the next cycle.
  - Expected: rf_we=0, busy_vec=0, and the pointer at 0 (a subsequent tie grants req0).
